// File: rtl/ffe_par2ser_pkg.sv
// Shared FFE output constants, word/sample types and the lane-slice helper.
// Lane k of a packed word sits at [(k+1)*NB_OUT-1 -: NB_OUT]; lane 0 is the oldest sample.
package ffe_par2ser_pkg;

  localparam int PARALLELISM = 8;
  localparam int NB_OUT      = 18;
  localparam int NBF_OUT     = 15;
  localparam int LANE_W      = $clog2(PARALLELISM);
  localparam int NB_WORD     = PARALLELISM * NB_OUT;

  typedef logic        [NB_WORD-1:0] word_t;
  typedef logic signed [NB_OUT-1:0]  sample_t;
  typedef logic        [LANE_W-1:0]  lane_t;

  typedef enum logic {
    ST_EMPTY,
    ST_SERIAL
  } state_t;

  localparam lane_t LANE_LAST = lane_t'(PARALLELISM - 1);

  function automatic sample_t lane_slice(input word_t w, input lane_t k);
    return w[int'(k) * NB_OUT +: NB_OUT];
  endfunction

endpackage

// File: rtl/ffe_par2ser_if.sv
// Word-in / sample-out handshake bundle of the FFE gearbox; o_symbol exists only
// with FFE_P2S_SLICE_EN.
interface ffe_par2ser_if;
  import ffe_par2ser_pkg::*;

  logic    i_valid;
  logic    o_ready;
  word_t   i_word;
  logic    o_valid;
  logic    i_ready;
  sample_t o_sample;
  logic    o_last;
`ifdef FFE_P2S_SLICE_EN
  logic    o_symbol;
`endif

  modport slave (
    input  i_valid, i_word, i_ready,
    output o_ready, o_valid, o_sample, o_last
`ifdef FFE_P2S_SLICE_EN
    , output o_symbol
`endif
  );

  modport master (
    output i_valid, i_word, i_ready,
    input  o_ready, o_valid, o_sample, o_last
`ifdef FFE_P2S_SLICE_EN
    , input  o_symbol
`endif
  );

endinterface

// File: rtl/ffe_par2ser_word_fifo2.sv
// ffe_word_fifo2: two-entry word FIFO (head = word being serialized, tail = next word).
// Exposes next-cycle head/full/empty so the caller can register its outputs from them.
module ffe_word_fifo2
  import ffe_par2ser_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t head_nxt,
  output logic  full_nxt,
  output logic  empty_nxt
);

  word_t      head;
  word_t      tail;
  word_t      tail_nxt;
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  // Caller never pushes while full nor pops while empty.
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    cnt_nxt  = cnt;
    case ({push, pop})
      2'b10: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd0) head_nxt = din;
        else             tail_nxt = din;
      end
      2'b01: begin
        cnt_nxt  = cnt - 2'd1;
        head_nxt = tail;
      end
      2'b11: begin
        if (cnt == 2'd1) begin
          head_nxt = din;
        end else begin
          head_nxt = tail;
          tail_nxt = din;
        end
      end
      default: ;
    endcase
  end

  assign full_nxt  = (cnt_nxt == 2'd2);
  assign empty_nxt = (cnt_nxt == 2'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ffe_par2ser.sv
// ffe_par2ser: PARALLELISM-lane word to one-sample-per-cycle gearbox; first sample 1 clk after accept,
// i_ready=0 or i_en=0 holds everything. FFE_P2S_SLICE_EN adds registered sign decision o_symbol.
module ffe_par2ser
  import ffe_par2ser_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  ffe_par2ser_if.slave bus
);

  state_t  state, state_nxt;
  lane_t   lane, lane_nxt;
  word_t   head_nxt;
  sample_t sample_nxt;
  sample_t sample_q;
  logic    full_nxt, empty_nxt;
  logic    push, take, pop;
  logic    rdy_q, valid_q, last_q;

  assign push = i_en & bus.i_valid & rdy_q;
  assign take = i_en & valid_q & bus.i_ready;
  assign pop  = take & (lane == LANE_LAST);

  ffe_word_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .din       (bus.i_word),
    .head_nxt  (head_nxt),
    .full_nxt  (full_nxt),
    .empty_nxt (empty_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst)      state <= ST_EMPTY;
    else if (i_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    case (state)
      ST_EMPTY: begin
        if (push) state_nxt = ST_SERIAL;
      end
      ST_SERIAL: begin
        if (take) begin
          if (lane == LANE_LAST) begin
            lane_nxt = '0;
            if (empty_nxt) state_nxt = ST_EMPTY;
          end else begin
            lane_nxt = lane + 1'b1;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign sample_nxt = lane_slice(head_nxt, lane_nxt);

  // Ready comes from next-cycle fullness, so a pop never lets a push through in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane     <= '0;
      rdy_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      sample_q <= '0;
    end else if (i_en) begin
      lane    <= lane_nxt;
      rdy_q   <= ~full_nxt;
      valid_q <= (state_nxt == ST_SERIAL);
      last_q  <= (state_nxt == ST_SERIAL) && (lane_nxt == LANE_LAST);
      if (state_nxt == ST_SERIAL) sample_q <= sample_nxt;
    end
  end

  assign bus.o_ready  = rdy_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_last   = last_q;
  assign bus.o_sample = sample_q;

`ifdef FFE_P2S_SLICE_EN
  logic symbol_q;

  always_ff @(posedge clk) begin
    if (!rst)                                  symbol_q <= 1'b0;
    else if (i_en && state_nxt == ST_SERIAL)   symbol_q <= ~sample_nxt[NB_OUT-1];
  end

  assign bus.o_symbol = symbol_q;
`endif

endmodule
